// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampling UART receiver. Configurable data width, optional
// even/odd parity, one or two stop bits, break detection, and a single-word
// holding register with a valid/ready handshake and overrun reporting.
module uart_rx_cfg #(
    parameter int DBITS     = 8,
    parameter int OSR       = 16,
    parameter int STOP_BITS = 1
) (
    input  logic             clk_100MHz,
    input  logic             reset_n,
    input  logic             rx,
    input  logic             sample_tick,
    input  logic [1:0]       parity_mode,
    input  logic             data_ready,
    output logic             data_valid,
    output logic [DBITS-1:0] data_out,
    output logic             frame_err,
    output logic             parity_err,
    output logic             break_det,
    output logic             overrun_err,
    output logic             rx_busy
);
    localparam int CW = $clog2(OSR);
    localparam int M  = OSR / 2;
    localparam int BW = (DBITS > 1) ? $clog2(DBITS) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(OSR - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(M - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(M);
    localparam logic [CW-1:0] CNT_DEC  = CW'(M + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DBITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BRK_WAIT
    } state_t;

    // Everything that travels with a completed frame into the holding register.
    typedef struct packed {
        logic [DBITS-1:0] data;
        logic             fe;
        logic             pe;
        logic             brk;
    } rx_word_t;

    state_t           state;
    logic             rx_meta;
    logic             rxs;
    logic [CW-1:0]    cnt;
    logic [BW-1:0]    bidx;
    logic             stop2;      // currently in the second stop bit
    logic [1:0]       par_q;      // parity mode frozen at start of frame
    logic [DBITS-1:0] shreg;
    logic             s_m1;       // sample at cnt = M-1
    logic             s_m;        // sample at cnt = M
    logic             par_acc;    // running XOR of data bits and parity bit
    logic             zero_acc;   // every decided bit so far was 0
    logic             fe_acc;     // a stop bit already decided as 0
    logic             brk_acc;    // break verdict taken at the first stop bit

    logic             tick_dec;
    logic             tick_last;
    logic             maj;
    logic             par_en;
    logic             frame_done;
    rx_word_t         done_word;

    assign tick_dec  = sample_tick && (cnt == CNT_DEC);
    assign tick_last = sample_tick && (cnt == CNT_LAST);
    // Third vote is the live synchronized value on the decision tick.
    assign maj       = (s_m1 & s_m) | (s_m1 & rxs) | (s_m & rxs);
    assign par_en    = (par_q == 2'b01) || (par_q == 2'b10);
    // Frame finishes mid-way through the last stop bit, not at its end.
    assign frame_done = (state == S_STOP) && tick_dec &&
                        ((STOP_BITS == 1) || stop2);

    // Word to be presented if the frame completes this cycle.
    always_comb begin
        done_word.data = shreg;
        done_word.fe   = fe_acc | ~maj;
        done_word.pe   = 1'b0;
        if (par_q == 2'b01)
            done_word.pe = par_acc;
        else if (par_q == 2'b10)
            done_word.pe = ~par_acc;
        done_word.brk  = stop2 ? brk_acc : (zero_acc & ~maj);
    end

    // Two-flop synchronizer for the asynchronous serial line, idles high.
    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // Receive FSM with bit-phase counter, majority sampling and output register.
    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            bidx        <= '0;
            stop2       <= 1'b0;
            par_q       <= 2'b00;
            shreg       <= '0;
            s_m1        <= 1'b1;
            s_m         <= 1'b1;
            par_acc     <= 1'b0;
            zero_acc    <= 1'b1;
            fe_acc      <= 1'b0;
            brk_acc     <= 1'b0;
            data_valid  <= 1'b0;
            data_out    <= '0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            break_det   <= 1'b0;
            overrun_err <= 1'b0;
            rx_busy     <= 1'b0;
        end else begin
            overrun_err <= 1'b0;

            // Holding register: load on completion if free or being drained
            // this same cycle, otherwise drop the new frame and flag overrun.
            if (frame_done) begin
                if (!data_valid || data_ready) begin
                    data_out   <= done_word.data;
                    frame_err  <= done_word.fe;
                    parity_err <= done_word.pe;
                    break_det  <= done_word.brk;
                    data_valid <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end

            // Bit-phase counter and mid-bit sample capture run only inside a frame.
            if (sample_tick && state != S_IDLE && state != S_BRK_WAIT) begin
                if (cnt == CNT_S0)
                    s_m1 <= rxs;
                if (cnt == CNT_S1)
                    s_m <= rxs;
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (!rxs) begin
                        state    <= S_START;
                        rx_busy  <= 1'b1;
                        cnt      <= '0;
                        bidx     <= '0;
                        stop2    <= 1'b0;
                        par_q    <= parity_mode;
                        par_acc  <= 1'b0;
                        zero_acc <= 1'b1;
                        fe_acc   <= 1'b0;
                        brk_acc  <= 1'b0;
                    end
                end

                S_START: begin
                    if (tick_dec && maj) begin
                        // Glitch, not a start bit.
                        state   <= S_IDLE;
                        rx_busy <= 1'b0;
                        cnt     <= '0;
                    end else if (tick_last) begin
                        state <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (tick_dec) begin
                        shreg    <= {maj, shreg[DBITS-1:1]};
                        par_acc  <= par_acc ^ maj;
                        zero_acc <= zero_acc & ~maj;
                    end
                    if (tick_last) begin
                        if (bidx == BIT_LAST)
                            state <= par_en ? S_PARITY : S_STOP;
                        else
                            bidx <= bidx + 1'b1;
                    end
                end

                S_PARITY: begin
                    if (tick_dec) begin
                        par_acc  <= par_acc ^ maj;
                        zero_acc <= zero_acc & ~maj;
                    end
                    if (tick_last)
                        state <= S_STOP;
                end

                S_STOP: begin
                    if (tick_dec) begin
                        if (!maj)
                            fe_acc <= 1'b1;
                        if (!stop2)
                            brk_acc <= zero_acc & ~maj;
                    end
                    if (frame_done) begin
                        state   <= done_word.brk ? S_BRK_WAIT : S_IDLE;
                        rx_busy <= done_word.brk;
                        cnt     <= '0;
                    end else if (tick_last) begin
                        // Only reachable on the first of two stop bits.
                        stop2 <= 1'b1;
                    end
                end

                S_BRK_WAIT: begin
                    // Line held low: wait for it to release before re-arming.
                    if (rxs) begin
                        state   <= S_IDLE;
                        rx_busy <= 1'b0;
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    rx_busy <= 1'b0;
                    cnt     <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Testbench for uart_rx_cfg: one-stop-bit and two-stop-bit instances,
// line driver aligned to sample ticks, expected-word scoreboard per instance.
module tb_uart_rx_cfg;
    localparam int OSR = 16;
    localparam int M   = OSR / 2;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
        logic       brk;
    } exp_t;

    logic       clk_100MHz = 1'b0;
    logic       sample_tick = 1'b0;
    logic       rst1_n, rst2_n, rx1, rx2, rdy1, rdy2;
    logic [1:0] pmode1, pmode2;
    logic       dv1, fe1, pe1, brk1, ovr1, busy1;
    logic       dv2, fe2, pe2, brk2, ovr2, busy2;
    logic [7:0] dout1, dout2;

    int   checks = 0;
    int   failures = 0;
    int   ovr_cnt1 = 0;
    int   ovr_cnt2 = 0;
    exp_t q1[$];
    exp_t q2[$];

    uart_rx_cfg #(.DBITS(8), .OSR(OSR), .STOP_BITS(1)) dut1 (
        .clk_100MHz(clk_100MHz), .reset_n(rst1_n), .rx(rx1), .sample_tick(sample_tick),
        .parity_mode(pmode1), .data_ready(rdy1), .data_valid(dv1), .data_out(dout1),
        .frame_err(fe1), .parity_err(pe1), .break_det(brk1), .overrun_err(ovr1),
        .rx_busy(busy1)
    );

    uart_rx_cfg #(.DBITS(8), .OSR(OSR), .STOP_BITS(2)) dut2 (
        .clk_100MHz(clk_100MHz), .reset_n(rst2_n), .rx(rx2), .sample_tick(sample_tick),
        .parity_mode(pmode2), .data_ready(rdy2), .data_valid(dv2), .data_out(dout2),
        .frame_err(fe2), .parity_err(pe2), .break_det(brk2), .overrun_err(ovr2),
        .rx_busy(busy2)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    // Tick on every third cycle, updated just after the rising edge.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk_100MHz);
            #1;
            sample_tick = (ph == 0);
            ph = (ph == 2) ? 0 : ph + 1;
        end
    end

    function automatic exp_t mk(input logic [7:0] d, input logic fe, input logic pe, input logic brk);
        exp_t e;
        e.d = d; e.fe = fe; e.pe = pe; e.brk = brk;
        return e;
    endfunction

    // Scoreboard for dut1: every accepted word must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_100MHz);
            #2;
            if (ovr1) ovr_cnt1++;
            if (dv1 && rdy1) begin
                checks++;
                if (q1.size() == 0) begin
                    failures++;
                    $display("FAIL dut1_unexpected_word got d=%h fe=%b pe=%b brk=%b want none", dout1, fe1, pe1, brk1);
                end else begin
                    e = q1.pop_front();
                    if ({dout1, fe1, pe1, brk1} !== e) begin
                        failures++;
                        $display("FAIL dut1_word got d=%h fe=%b pe=%b brk=%b want d=%h fe=%b pe=%b brk=%b",
                                 dout1, fe1, pe1, brk1, e.d, e.fe, e.pe, e.brk);
                    end
                end
            end
        end
    end

    // Scoreboard for dut2.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_100MHz);
            #2;
            if (ovr2) ovr_cnt2++;
            if (dv2 && rdy2) begin
                checks++;
                if (q2.size() == 0) begin
                    failures++;
                    $display("FAIL dut2_unexpected_word got d=%h fe=%b pe=%b brk=%b want none", dout2, fe2, pe2, brk2);
                end else begin
                    e = q2.pop_front();
                    if ({dout2, fe2, pe2, brk2} !== e) begin
                        failures++;
                        $display("FAIL dut2_word got d=%h fe=%b pe=%b brk=%b want d=%h fe=%b pe=%b brk=%b",
                                 dout2, fe2, pe2, brk2, e.d, e.fe, e.pe, e.brk);
                    end
                end
            end
        end
    end

    // Hold one bit on the line for OSR ticks; optionally pulse rdy1 on tick rdy_tick.
    task automatic put_bit(input int which, input logic b, input int rdy_tick);
        int k;
        k = 0;
        if (which == 1) rx1 = b; else rx2 = b;
        while (k < OSR) begin
            @(negedge clk_100MHz);
            if (which == 1 && rdy_tick != 0) rdy1 = 1'b0;
            if (sample_tick) begin
                k++;
                if (which == 1 && k == rdy_tick) rdy1 = 1'b1;
            end
        end
    endtask

    task automatic idle_bits(input int which, input int n);
        for (int i = 0; i < n; i++) put_bit(which, 1'b1, 0);
    endtask

    // Start bit begins on a tick cycle so driver and receiver tick counts line up.
    task automatic send_frame(input int which, input logic [7:0] d, input logic par_en,
                              input logic pbit, input logic [1:0] stops, input int rdy_tick);
        int nstop;
        nstop = (which == 1) ? 1 : 2;
        while (!sample_tick) @(negedge clk_100MHz);
        put_bit(which, 1'b0, 0);
        for (int i = 0; i < 8; i++) put_bit(which, d[i], 0);
        if (par_en) put_bit(which, pbit, 0);
        for (int s = 0; s < nstop; s++) put_bit(which, stops[s], (s == nstop - 1) ? rdy_tick : 0);
        if (which == 1) rx1 = 1'b1; else rx2 = 1'b1;
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk_100MHz);
        checks++;
        if ({dv1, fe1, pe1, brk1, ovr1, busy1} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags1 got %b want 000000", {dv1, fe1, pe1, brk1, ovr1, busy1});
        end
        checks++;
        if (dout1 !== 8'h00) begin failures++; $display("FAIL reset_data1 got %h want 00", dout1); end
        checks++;
        if ({dv2, fe2, pe2, brk2, ovr2, busy2} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags2 got %b want 000000", {dv2, fe2, pe2, brk2, ovr2, busy2});
        end
        checks++;
        if (dout2 !== 8'h00) begin failures++; $display("FAIL reset_data2 got %h want 00", dout2); end
        rst1_n = 1'b1;
        rst2_n = 1'b1;
        repeat (6) @(negedge clk_100MHz);
    endtask

    task automatic test_basic();
        logic busy_mid;
        busy_mid = 1'b0;
        q1.push_back(mk(8'hA5, 1'b0, 1'b0, 1'b0));
        fork
            send_frame(1, 8'hA5, 1'b0, 1'b0, 2'b11, 0);
            begin
                repeat (5 * OSR * 3) @(negedge clk_100MHz);
                busy_mid = busy1;
            end
        join
        checks++;
        if (busy_mid !== 1'b1) begin failures++; $display("FAIL basic_busy_mid got %b want 1", busy_mid); end
        checks++;
        if (busy1 !== 1'b0) begin failures++; $display("FAIL basic_busy_end got %b want 0", busy1); end
        checks++;
        if (q1.size() != 0) begin failures++; $display("FAIL basic_drain pending=%0d want 0", q1.size()); end
        // Word was accepted: valid drops but data stays.
        checks++;
        if ({dv1, dout1} !== {1'b0, 8'hA5}) begin
            failures++;
            $display("FAIL basic_hold got dv=%b d=%h want dv=0 d=a5", dv1, dout1);
        end
    endtask

    task automatic test_parity();
        pmode1 = 2'b01;
        q1.push_back(mk(8'h3C, 1'b0, 1'b0, 1'b0));
        send_frame(1, 8'h3C, 1'b1, 1'b0, 2'b11, 0);
        q1.push_back(mk(8'h3C, 1'b0, 1'b1, 1'b0));
        send_frame(1, 8'h3C, 1'b1, 1'b1, 2'b11, 0);
        pmode1 = 2'b10;
        q1.push_back(mk(8'h3C, 1'b0, 1'b0, 1'b0));
        send_frame(1, 8'h3C, 1'b1, 1'b1, 2'b11, 0);
        // Mode switched to none mid-frame: the odd-parity check still applies.
        q1.push_back(mk(8'h3C, 1'b0, 1'b1, 1'b0));
        fork
            send_frame(1, 8'h3C, 1'b1, 1'b0, 2'b11, 0);
            begin
                repeat (2 * OSR * 3) @(negedge clk_100MHz);
                pmode1 = 2'b00;
            end
        join
        idle_bits(1, 1);
        checks++;
        if (q1.size() != 0) begin failures++; $display("FAIL parity_drain pending=%0d want 0", q1.size()); end
    endtask

    task automatic test_false_start();
        int   k;
        logic seen_dv, seen_busy;
        k = 0; seen_dv = 1'b0; seen_busy = 1'b0;
        while (!sample_tick) @(negedge clk_100MHz);
        rx1 = 1'b0;
        while (k < 4) begin
            @(negedge clk_100MHz);
            if (sample_tick) k++;
            if (busy1) seen_busy = 1'b1;
        end
        rx1 = 1'b1;
        for (int i = 0; i < 3 * OSR * 3; i++) begin
            @(negedge clk_100MHz);
            if (dv1) seen_dv = 1'b1;
            if (busy1) seen_busy = 1'b1;
        end
        checks++;
        if (seen_busy !== 1'b1) begin failures++; $display("FAIL false_start_busy got %b want 1", seen_busy); end
        checks++;
        if (seen_dv !== 1'b0) begin failures++; $display("FAIL false_start_valid got %b want 0", seen_dv); end
        checks++;
        if (busy1 !== 1'b0) begin failures++; $display("FAIL false_start_idle got %b want 0", busy1); end
    endtask

    task automatic test_frame_err();
        q1.push_back(mk(8'h55, 1'b1, 1'b0, 1'b0));
        send_frame(1, 8'h55, 1'b0, 1'b0, 2'b00, 0);
        idle_bits(1, 2);
        checks++;
        if (q1.size() != 0) begin failures++; $display("FAIL frame_err_drain pending=%0d want 0", q1.size()); end
    endtask

    task automatic test_break();
        q1.push_back(mk(8'h00, 1'b1, 1'b0, 1'b1));
        while (!sample_tick) @(negedge clk_100MHz);
        for (int i = 0; i < 12; i++) put_bit(1, 1'b0, 0);
        checks++;
        if (busy1 !== 1'b1) begin failures++; $display("FAIL break_wait_busy got %b want 1", busy1); end
        checks++;
        if (q1.size() != 0) begin failures++; $display("FAIL break_drain pending=%0d want 0", q1.size()); end
        idle_bits(1, 2);
        checks++;
        if (busy1 !== 1'b0) begin failures++; $display("FAIL break_release got %b want 0", busy1); end
        q1.push_back(mk(8'h81, 1'b0, 1'b0, 1'b0));
        send_frame(1, 8'h81, 1'b0, 1'b0, 2'b11, 0);
        idle_bits(1, 1);
        checks++;
        if (q1.size() != 0) begin failures++; $display("FAIL after_break_drain pending=%0d want 0", q1.size()); end
    endtask

    task automatic test_back_to_back();
        q1.push_back(mk(8'h3A, 1'b0, 1'b0, 1'b0));
        q1.push_back(mk(8'hC5, 1'b0, 1'b0, 1'b0));
        send_frame(1, 8'h3A, 1'b0, 1'b0, 2'b11, 0);
        send_frame(1, 8'hC5, 1'b0, 1'b0, 2'b11, 0);
        idle_bits(1, 1);
        checks++;
        if (q1.size() != 0) begin failures++; $display("FAIL b2b_drain pending=%0d want 0", q1.size()); end
    endtask

    task automatic test_overrun();
        int base, t;
        base = ovr_cnt1;
        rdy1 = 1'b0;
        q1.push_back(mk(8'h11, 1'b0, 1'b0, 1'b0));
        send_frame(1, 8'h11, 1'b0, 1'b0, 2'b11, 0);
        idle_bits(1, 1);
        send_frame(1, 8'h22, 1'b0, 1'b0, 2'b11, 0);
        idle_bits(1, 1);
        checks++;
        if (ovr_cnt1 - base !== 1) begin failures++; $display("FAIL overrun_pulse got %0d want 1", ovr_cnt1 - base); end
        checks++;
        if ({dv1, dout1} !== {1'b1, 8'h11}) begin
            failures++;
            $display("FAIL overrun_hold got dv=%b d=%h want dv=1 d=11", dv1, dout1);
        end
        // Ready raised only on the completion cycle: old word drains, new word loads.
        q1.push_back(mk(8'h22, 1'b0, 1'b0, 1'b0));
        send_frame(1, 8'h22, 1'b0, 1'b0, 2'b11, M + 2);
        idle_bits(1, 1);
        checks++;
        if (ovr_cnt1 - base !== 1) begin failures++; $display("FAIL overrun_same_cycle got %0d want 1", ovr_cnt1 - base); end
        checks++;
        if ({dv1, dout1} !== {1'b1, 8'h22}) begin
            failures++;
            $display("FAIL overrun_reload got dv=%b d=%h want dv=1 d=22", dv1, dout1);
        end
        rdy1 = 1'b1;
        t = 0;
        while (q1.size() != 0 && t < 200) begin @(negedge clk_100MHz); t++; end
        checks++;
        if (q1.size() != 0) begin failures++; $display("FAIL overrun_drain pending=%0d want 0", q1.size()); end
    endtask

    task automatic test_stop2();
        q2.push_back(mk(8'h0F, 1'b1, 1'b0, 1'b0));
        send_frame(2, 8'h0F, 1'b0, 1'b0, 2'b01, 0);
        idle_bits(2, 2);
        q2.push_back(mk(8'h5A, 1'b0, 1'b0, 1'b0));
        send_frame(2, 8'h5A, 1'b0, 1'b0, 2'b11, 0);
        idle_bits(2, 1);
        checks++;
        if (q2.size() != 0) begin failures++; $display("FAIL stop2_drain pending=%0d want 0", q2.size()); end
        checks++;
        if (ovr_cnt2 !== 0) begin failures++; $display("FAIL stop2_overrun got %0d want 0", ovr_cnt2); end
    endtask

    task automatic test_mid_reset();
        int k;
        k = 0;
        while (!sample_tick) @(negedge clk_100MHz);
        for (int i = 0; i < 4; i++) put_bit(2, 1'b0, 0);
        rx2 = 1'b0;
        while (k < 8) begin
            @(negedge clk_100MHz);
            if (sample_tick) k++;
        end
        checks++;
        if (busy2 !== 1'b1) begin failures++; $display("FAIL mid_reset_busy_before got %b want 1", busy2); end
        rst2_n = 1'b0;
        repeat (3) @(negedge clk_100MHz);
        rx2 = 1'b1;
        checks++;
        if ({dv2, fe2, pe2, brk2, ovr2, busy2} !== 6'b0) begin
            failures++;
            $display("FAIL mid_reset_flags got %b want 000000", {dv2, fe2, pe2, brk2, ovr2, busy2});
        end
        checks++;
        if (dout2 !== 8'h00) begin failures++; $display("FAIL mid_reset_data got %h want 00", dout2); end
        rst2_n = 1'b1;
        idle_bits(2, 3);
        checks++;
        if ({dv2, busy2} !== 2'b00) begin
            failures++;
            $display("FAIL mid_reset_abort got dv=%b busy=%b want 0 0", dv2, busy2);
        end
        q2.push_back(mk(8'hC3, 1'b0, 1'b0, 1'b0));
        send_frame(2, 8'hC3, 1'b0, 1'b0, 2'b11, 0);
        idle_bits(2, 1);
        checks++;
        if (q2.size() != 0) begin failures++; $display("FAIL mid_reset_next pending=%0d want 0", q2.size()); end
    endtask

    initial begin
        rst1_n = 1'b0; rst2_n = 1'b0;
        rx1 = 1'b1; rx2 = 1'b1;
        rdy1 = 1'b1; rdy2 = 1'b1;
        pmode1 = 2'b00; pmode2 = 2'b00;
        test_reset();
        test_basic();
        test_parity();
        test_false_start();
        test_frame_err();
        test_break();
        test_back_to_back();
        test_overrun();
        test_stop2();
        test_mid_reset();
        repeat (10) @(negedge clk_100MHz);
        checks++;
        if (q1.size() + q2.size() != 0) begin
            failures++;
            $display("FAIL final_pending got %0d want 0", q1.size() + q2.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
